// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: holds one instruction, waits for the
// data-SRAM load response, extracts/extends load data and packs the WB bus.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 147,
  parameter int MS_TO_WS_BUS_WD = 109
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_flush,
  output logic [4:0]                 MS_dest,
  output logic [31:0]                MS_dest_data,
  output logic                       MS_load_pending,
  output logic                       MS_EX
);

  logic                       r_vld_p1;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus_p1;
  logic                       r_buf_vld_p1;
  logic [31:0]                r_buf_p1;
  logic [1:0]                 r_discard_cnt;

  logic [31:0] w_badvaddr;
  logic [4:0]  w_ex_code;
  logic        w_eret;
  logic        w_bd;
  logic        w_mem_req;
  logic [2:0]  w_load_op;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_rt_old;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;

  logic        w_has_ex;
  logic        w_accept_ok;
  logic        w_ready_go;
  logic        w_disc_inc;
  logic        w_disc_dec;
  logic [31:0] w_rd;
  logic [31:0] w_final_result;

  assign w_badvaddr   = r_bus_p1[146:115];
  assign w_ex_code    = r_bus_p1[114:110];
  assign w_eret       = r_bus_p1[109];
  assign w_bd         = r_bus_p1[108];
  assign w_mem_req    = r_bus_p1[107];
  assign w_load_op    = r_bus_p1[106:104];
  assign w_addr_lo    = r_bus_p1[103:102];
  assign w_rt_old     = r_bus_p1[101:70];
  assign w_gr_we      = r_bus_p1[69];
  assign w_dest       = r_bus_p1[68:64];
  assign w_alu_result = r_bus_p1[63:32];
  assign w_pc         = r_bus_p1[31:0];

  function automatic logic [31:0] load_extract(
    input logic [2:0]  op,
    input logic [1:0]  b,
    input logic [31:0] rt,
    input logic [31:0] alu,
    input logic [31:0] rd
  );
    logic        [7:0]  ub;
    logic        [15:0] uh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    logic        [31:0] res;
    case (b)
      2'd0:    ub = rd[7:0];
      2'd1:    ub = rd[15:8];
      2'd2:    ub = rd[23:16];
      default: ub = rd[31:24];
    endcase
    uh  = b[1] ? rd[31:16] : rd[15:0];
    sb  = $signed(ub);
    sh  = $signed(uh);
    sx  = '0;
    res = alu;
    case (op)
      3'd1: begin sx = sb; res = sx; end
      3'd2: res = {24'd0, ub};
      3'd3: begin sx = sh; res = sx; end
      3'd4: res = {16'd0, uh};
      3'd5: res = rd;
      3'd6: begin
        case (b)
          2'd0:    res = {rd[7:0],  rt[23:0]};
          2'd1:    res = {rd[15:0], rt[15:0]};
          2'd2:    res = {rd[23:0], rt[7:0]};
          default: res = rd;
        endcase
      end
      3'd7: begin
        case (b)
          2'd0:    res = rd;
          2'd1:    res = {rt[31:24], rd[31:8]};
          2'd2:    res = {rt[31:16], rd[31:16]};
          default: res = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: res = alu;
    endcase
    return res;
  endfunction

  // A response is ours only if no stale responses are still owed to flushed loads.
  assign w_has_ex    = (w_ex_code != 5'd0) | w_eret;
  assign w_accept_ok = data_sram_data_ok & (r_discard_cnt == 2'd0) & r_vld_p1 & w_mem_req
                     & ~r_buf_vld_p1 & ~w_has_ex;
  assign w_ready_go  = ~w_mem_req | w_has_ex | r_buf_vld_p1 | w_accept_ok;

  assign ms_allowin     = ~r_vld_p1 | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_vld_p1 & w_ready_go;

  assign w_rd           = r_buf_vld_p1 ? r_buf_p1 : data_sram_rdata;
  assign w_final_result = load_extract(w_load_op, w_addr_lo, w_rt_old, w_alu_result, w_rd);

  assign ms_to_ws_bus = {w_badvaddr, w_ex_code, w_eret, w_bd, w_gr_we, w_dest,
                         w_final_result, w_pc};

  assign MS_dest         = w_dest & {5{r_vld_p1 & w_gr_we}};
  assign MS_dest_data    = w_final_result;
  assign MS_load_pending = r_vld_p1 & w_mem_req & ~w_ready_go;
  assign MS_EX           = r_vld_p1 & w_has_ex;

  assign w_disc_inc = ws_flush & r_vld_p1 & w_mem_req & ~r_buf_vld_p1 & ~w_accept_ok;
  assign w_disc_dec = data_sram_data_ok & (r_discard_cnt != 2'd0);

  // ---- stage boundary: EX -> MEM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_buf_vld_p1 <= 1'b0;
    end else if (ws_flush) begin
      r_vld_p1 <= 1'b0;
    end else begin
      if (ms_allowin) r_vld_p1 <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) r_buf_vld_p1 <= 1'b0;
      else if (w_accept_ok && !ws_allowin) r_buf_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_bus_p1 <= '0;
    else if (!ws_flush && es_to_ms_valid && ms_allowin) r_bus_p1 <= es_to_ms_bus;
  end

  always_ff @(posedge clk) begin
    if (w_accept_ok && !ws_allowin) r_buf_p1 <= data_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard_cnt <= 2'd0;
    end else begin
      case ({w_disc_inc, w_disc_dec})
        2'b10:   if (r_discard_cnt != 2'd3) r_discard_cnt <= r_discard_cnt + 2'd1;
        2'b01:   r_discard_cnt <= r_discard_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load scenarios plus randomized
// loads compared against a shift/mask model of MIPS load extraction.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [146:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [108:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_flush;
  logic [4:0]   MS_dest;
  logic [31:0]  MS_dest_data;
  logic         MS_load_pending;
  logic         MS_EX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_flush          (ws_flush),
    .MS_dest           (MS_dest),
    .MS_dest_data      (MS_dest_data),
    .MS_load_pending   (MS_load_pending),
    .MS_EX             (MS_EX)
  );

  function automatic logic [146:0] mk_bus(
    input logic [31:0] badv, input logic [4:0] exc, input logic eret, input logic bd,
    input logic mreq, input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rt,
    input logic we, input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    return {badv, exc, eret, bd, mreq, op, lo, rt, we, dest, alu, pc};
  endfunction

  // Reference: little-endian loads expressed as shifts and masks.
  function automatic logic [31:0] model_load(
    input logic [2:0] op, input logic [1:0] b, input logic [31:0] rt,
    input logic [31:0] alu, input logic [31:0] rd);
    logic [31:0] byt;
    logic [31:0] hw;
    int          sh;
    sh  = 8 * int'(b);
    byt = (rd >> sh) & 32'hFF;
    hw  = (rd >> (16 * int'(b[1]))) & 32'hFFFF;
    case (op)
      3'd0: return alu;
      3'd1: return (byt >= 32'h80) ? (byt | 32'hFFFFFF00) : byt;
      3'd2: return byt;
      3'd3: return (hw >= 32'h8000) ? (hw | 32'hFFFF0000) : hw;
      3'd4: return hw;
      3'd5: return rd;
      3'd6: return (rd << (24 - sh)) | (rt & (32'hFFFFFFFF >> (sh + 8)));
      default: return (rd >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
    endcase
  endfunction

  task automatic quiet();
    logic [159:0] g;
    g = {$urandom, $urandom, $urandom, $urandom, $urandom};
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = g[146:0];
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    ws_flush          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ms_to_ws_valid); end
    checks++; if (ms_to_ws_bus !== 109'd0) begin errors++; $display("FAIL reset_bus got %h want 0", ms_to_ws_bus); end
    checks++; if ({MS_dest, MS_dest_data, MS_load_pending, MS_EX} !== 39'd0) begin
      errors++; $display("FAIL reset_fwd got %h/%h/%b/%b want 0", MS_dest, MS_dest_data, MS_load_pending, MS_EX); end
    reset = 1'b0;
  endtask

  // One load through the stage: wait_n idle cycles before data_ok, then stall_n
  // cycles with ws_allowin low (rdata turns to garbage after the first).
  task automatic run_load(input string name, input logic [2:0] op, input logic [1:0] lo,
                          input logic [31:0] rt, input logic [31:0] alu, input logic [31:0] rd,
                          input logic [31:0] exp, input int wait_n, input int stall_n);
    logic [31:0]  badv, pc;
    logic [4:0]   dest;
    logic         we, bd;
    logic [108:0] exp_bus;
    badv = $urandom; pc = $urandom; dest = 5'($urandom); we = 1'($urandom); bd = 1'($urandom);
    exp_bus = {badv, 5'd0, 1'b0, bd, we, dest, exp, pc};
    @(negedge clk);
    quiet();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(badv, 5'd0, 1'b0, bd, op != 3'd0, op, lo, rt, we, dest, alu, pc);
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL %s accept_allowin got %b want 1", name, ms_allowin); end
    @(negedge clk);
    quiet();
    if (op != 3'd0) begin
      for (int i = 0; i < wait_n; i++) begin
        #1;
        checks++; if ({MS_load_pending, ms_to_ws_valid, ms_allowin} !== 3'b100) begin
          errors++; $display("FAIL %s wait pend/valid/allowin got %b%b%b want 100", name, MS_load_pending, ms_to_ws_valid, ms_allowin); end
        @(negedge clk);
      end
    end
    data_sram_data_ok = (op != 3'd0);
    data_sram_rdata   = rd;
    ws_allowin        = (stall_n == 0);
    #1;
    checks++; if ({ms_to_ws_valid, MS_load_pending} !== 2'b10) begin
      errors++; $display("FAIL %s resp valid/pend got %b%b want 10", name, ms_to_ws_valid, MS_load_pending); end
    checks++; if (MS_dest_data !== exp) begin errors++; $display("FAIL %s result got %h want %h", name, MS_dest_data, exp); end
    checks++; if (MS_dest !== (we ? dest : 5'd0)) begin errors++; $display("FAIL %s dest got %0d want %0d", name, MS_dest, we ? dest : 5'd0); end
    checks++; if (ms_allowin !== (stall_n == 0)) begin errors++; $display("FAIL %s resp_allowin got %b want %b", name, ms_allowin, stall_n == 0); end
    if (stall_n == 0) begin
      checks++; if (ms_to_ws_bus !== exp_bus) begin errors++; $display("FAIL %s bus got %h want %h", name, ms_to_ws_bus, exp_bus); end
    end
    for (int i = 1; i <= stall_n; i++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      ws_allowin        = (i == stall_n);
      #1;
      checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_bus) begin
        errors++; $display("FAIL %s held valid=%b bus got %h want %h", name, ms_to_ws_valid, ms_to_ws_bus, exp_bus); end
      checks++; if (ms_allowin !== (i == stall_n)) begin errors++; $display("FAIL %s held_allowin got %b want %b", name, ms_allowin, i == stall_n); end
    end
    @(negedge clk);
    quiet();
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL %s leave_valid got %b want 0", name, ms_to_ws_valid); end
  endtask

  task automatic test_lw();
    run_load("lw", 3'd5, 2'd0, $urandom, $urandom, 32'h8899AABB, 32'h8899AABB, 1, 0);
  endtask

  task automatic test_extract();
    run_load("lb",  3'd1, 2'd2, $urandom, $urandom, 32'h00F30000, 32'hFFFFFFF3, 0, 0);
    run_load("lbu", 3'd2, 2'd2, $urandom, $urandom, 32'h00F30000, 32'h000000F3, 0, 0);
    run_load("lhu", 3'd4, 2'd2, $urandom, $urandom, 32'h80010000, 32'h00008001, 0, 0);
    run_load("lwl", 3'd6, 2'd1, 32'h11223344, $urandom, 32'hAABBCCDD, 32'hCCDD3344, 0, 0);
    run_load("lwr", 3'd7, 2'd2, 32'h11223344, $urandom, 32'hAABBCCDD, 32'h1122AABB, 1, 0);
    run_load("alu", 3'd0, 2'd0, $urandom, 32'h13572468, $urandom, 32'h13572468, 0, 0);
  endtask

  task automatic test_buffer();
    run_load("buffer", 3'd5, 2'd0, $urandom, $urandom, 32'hCAFEF00D, 32'hCAFEF00D, 1, 3);
  endtask

  task automatic test_flush();
    // Flush on an empty stage must not capture the incoming bus.
    @(negedge clk);
    quiet();
    ws_flush = 1'b1; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 0, 1'b1, 5'd9, 32'h1, 32'h2);
    @(negedge clk);
    quiet();
    #1;
    checks++; if ({ms_to_ws_valid, MS_dest} !== 6'd0) begin
      errors++; $display("FAIL flush_ignore valid/dest got %b/%0d want 0/0", ms_to_ws_valid, MS_dest); end
    // Outstanding load flushed; its late response must hit the next load's first cycle and be dropped.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 0, 1'b1, 5'd3, 0, 32'h100);
    @(negedge clk);
    quiet();
    ws_flush = 1'b1;
    #1;
    checks++; if (MS_load_pending !== 1'b1) begin errors++; $display("FAIL flush_pend got %b want 1", MS_load_pending); end
    @(negedge clk);
    quiet();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 0, 1'b1, 5'd4, 0, 32'h104);
    #1;
    checks++; if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin
      errors++; $display("FAIL flush_empty valid/allowin got %b%b want 01", ms_to_ws_valid, ms_allowin); end
    @(negedge clk);
    quiet();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADDEAD;
    #1;
    checks++; if ({ms_to_ws_valid, MS_load_pending} !== 2'b01) begin
      errors++; $display("FAIL stale_drop valid/pend got %b%b want 01", ms_to_ws_valid, MS_load_pending); end
    @(negedge clk);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADBEEF;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1 || MS_dest_data !== 32'h0BADBEEF) begin
      errors++; $display("FAIL flush_next got %b/%h want 1/0badbeef", ms_to_ws_valid, MS_dest_data); end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_exception();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      quiet();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(32'h0000BEEF, (k == 0) ? 5'd4 : 5'd0, k == 1, 1'b0, 1'b1, 3'd5, 2'd0,
                            0, 1'b1, 5'd7, 0, 32'h200);
      @(negedge clk);
      quiet();
      #1;
      checks++; if ({ms_to_ws_valid, MS_EX, MS_load_pending} !== 3'b110) begin
        errors++; $display("FAIL ex%0d valid/ex/pend got %b%b%b want 110", k, ms_to_ws_valid, MS_EX, MS_load_pending); end
      checks++; if (ms_to_ws_bus[108:72] !== {32'h0000BEEF, (k == 0) ? 5'd4 : 5'd0} || ms_to_ws_bus[71] !== (k == 1)) begin
        errors++; $display("FAIL ex%0d fields got %h want badv beef", k, ms_to_ws_bus[108:71]); end
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    quiet();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 0, 1'b1, 5'd8, 0, 32'h300);
    @(negedge clk);
    quiet();
    ws_flush = 1'b1;
    @(negedge clk);
    quiet();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 0, 1'b1, 5'd8, 0, 32'h304);
    @(negedge clk);
    quiet();
    reset = 1'b1;
    #1;
    checks++; if (MS_load_pending !== 1'b1) begin errors++; $display("FAIL midload_pend got %b want 1", MS_load_pending); end
    @(negedge clk);
    #1;
    checks++; if ({ms_to_ws_valid, ms_to_ws_bus, MS_dest, MS_dest_data, MS_load_pending, MS_EX} !== 149'd0 || ms_allowin !== 1'b1) begin
      errors++; $display("FAIL midload_reset got valid=%b bus=%h dest=%0d allowin=%b want zeros and allowin=1",
                         ms_to_ws_valid, ms_to_ws_bus, MS_dest, ms_allowin); end
    reset = 1'b0;
    run_load("after_reset", 3'd5, 2'd0, $urandom, $urandom, 32'h600DF00D, 32'h600DF00D, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [2:0]  op;
      logic [1:0]  lo;
      logic [31:0] rt, alu, rd;
      op = 3'($urandom); lo = 2'($urandom); rt = $urandom; alu = $urandom; rd = $urandom;
      run_load("random", op, lo, rt, alu, rd, model_load(op, lo, rt, alu, rd),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extract();
    test_buffer();
    test_flush();
    test_exception();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
